// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the CPU control unit and alu_seq.
// The control unit drives start/op/a/b; the ALU returns results, flags and handshake.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] H;
  logic             C;
  logic             Z;
  logic             N;
  logic             OV;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  F, H, C, Z, N, OV, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output F, H, C, Z, N, OV, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with carry-chained add/sub, shift-add multiply
// and restoring divide; results and flags are registered.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_INC = 4'h3;
  localparam logic [3:0] OP_DEC = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAL = 4'hA;
  localparam logic [3:0] OP_SAR = 4'hB;
  localparam logic [3:0] OP_ADC = 4'hC;
  localparam logic [3:0] OP_SBC = 4'hD;
  localparam logic [3:0] OP_MUL = 4'hE;
  localparam logic [3:0] OP_DIV = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;
  logic             busy;

  logic [WIDTH-1:0] y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             sum_ov;
  logic [WIDTH-1:0] alu_f;
  logic [WIDTH-1:0] alu_h;
  logic             alu_c;
  logic             alu_ov;

  // All add/sub flavours share one adder: a + y + cin.
  always_comb begin
    y   = '0;
    cin = 1'b0;
    case (bus.op)
      OP_ADD: y = bus.b;
      OP_SUB: begin y = ~bus.b; cin = 1'b1; end
      OP_INC: cin = 1'b1;
      OP_DEC: y = '1;
      OP_ADC: begin y = bus.b; cin = c_q; end
      OP_SBC: begin y = ~bus.b; cin = c_q; end
      default: ;
    endcase
    sum    = {1'b0, bus.a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    sum_ov = (bus.a[WIDTH-1] == y[WIDTH-1])
           & (sum[WIDTH-1] != bus.a[WIDTH-1]);
  end

  always_comb begin
    alu_f  = '0;
    alu_h  = '0;
    alu_c  = 1'b0;
    alu_ov = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBC: begin
        alu_f  = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_ov = sum_ov;
      end
      OP_AND: alu_f = bus.a & bus.b;
      OP_OR:  alu_f = bus.a | bus.b;
      OP_NOT: alu_f = ~bus.a;
      OP_SHL: begin
        alu_f = {bus.a[WIDTH-2:0], 1'b0};
        alu_c = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        alu_f = {1'b0, bus.a[WIDTH-1:1]};
        alu_c = bus.a[0];
      end
      OP_SAL: begin
        alu_f  = {bus.a[WIDTH-2:0], 1'b0};
        alu_c  = bus.a[WIDTH-1];
        alu_ov = bus.a[WIDTH-1] ^ bus.a[WIDTH-2];
      end
      OP_SAR: begin
        alu_f = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
        alu_c = bus.a[0];
      end
      OP_DIV: begin
        // only reaches here with b == 0
        alu_f  = '1;
        alu_h  = bus.a;
        alu_ov = 1'b1;
      end
      default: ;
    endcase
  end

  logic [WIDTH:0]   psum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH-1:0] dsub;
  logic [WIDTH-1:0] div_hi, div_lo;

  always_comb begin
    psum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
    mul_hi = psum[WIDTH:1];
    mul_lo = {psum[0], lo_q[WIDTH-1:1]};
    sh     = {hi_q, lo_q[WIDTH-1]};
    ge     = sh >= {1'b0, x_q};
    dsub   = sh[WIDTH-1:0] - x_q;
    div_hi = ge ? dsub : sh[WIDTH-1:0];
    div_lo = {lo_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      f_q     <= '0;
      h_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      f_q     <= f_d;
      h_q     <= h_d;
      c_q     <= c_d;
      z_q     <= z_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    f_d     = f_q;
    h_d     = h_q;
    c_d     = c_q;
    ov_d    = ov_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          hi_d  = '0;
          if (bus.op == OP_MUL) begin
            state_d = S_MUL;
            x_d     = bus.a;
            lo_d    = bus.b;
          end else if (bus.op == OP_DIV && bus.b != '0) begin
            state_d = S_DIV;
            x_d     = bus.b;
            lo_d    = bus.a;
          end else begin
            f_d    = alu_f;
            h_d    = alu_h;
            c_d    = alu_c;
            ov_d   = alu_ov;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        hi_d  = mul_hi;
        lo_d  = mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          f_d     = mul_lo;
          h_d     = mul_hi;
          c_d     = mul_hi != '0;
          ov_d    = mul_hi != '0;
          done_d  = 1'b1;
        end
      end
      S_DIV: begin
        hi_d  = div_hi;
        lo_d  = div_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          f_d     = div_lo;
          h_d     = div_hi;
          c_d     = 1'b0;
          ov_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    z_d = done_d ? (f_d == '0)     : z_q;
    n_d = done_d ? f_d[WIDTH-1]    : n_q;
  end

  always_comb begin
    busy = state_q != S_IDLE;
  end

  assign bus.F    = f_q;
  assign bus.H    = h_q;
  assign bus.C    = c_q;
  assign bus.Z    = z_q;
  assign bus.N    = n_q;
  assign bus.OV   = ov_q;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule
